fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, PC value loaded on reset.
REQ-002 Parameter DEPTH, fixed at 2, number of fetch buffer entries; other values are not supported.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 fetch_en  input  1  fetch permitted this cycle; 0 holds PC and performs no enqueue.
REQ-006 redirect_valid  input  1  branch/jump/exception redirect request.
REQ-007 redirect_pc  input  32  redirect target byte address.
REQ-008 imem_a  output  11  word index to instruction memory; equals pc[12:2] combinationally.
REQ-009 imem_rd  input  32  instruction word from memory, combinational in imem_a, same cycle.
REQ-010 instr_valid  output  1  buffer head holds a valid instruction.
REQ-011 instr_ready  input  1  downstream decode accepts head this cycle.
REQ-012 instr  output  32  head instruction word; 0 when buffer empty.
REQ-013 instr_pc  output  32  byte address of head instruction; 0 when buffer empty.

Function
REQ-014 Internal pc register shall be 32 bits; imem_a = pc[12:2], so memory index wraps every 8 KB of PC space.
REQ-015 Occupancy state machine shall have states EMPTY (0 entries), ONE (1), FULL (2).
REQ-016 deq = instr_valid & instr_ready & ~redirect_valid.
REQ-017 enq = fetch_en & ~redirect_valid & (state != FULL | deq).
REQ-018 On enq, {pc, imem_rd} shall be written at the buffer tail and pc shall advance to pc + 4, wrapping modulo 2^32 (32'hFFFFFFFC + 4 = 0).
REQ-019 On deq, the head entry shall be removed; entries leave in fetch order.
REQ-020 Transitions: EMPTY->ONE on enq; ONE->EMPTY on deq & ~enq; ONE->FULL on enq & ~deq; FULL->ONE on deq & ~enq; enq & deq together leave state unchanged.
REQ-021 Simultaneous enq and deq in ONE shall pass the new entry to the head with no bubble; in FULL, the freed slot shall be refilled in the same cycle.
REQ-022 Latency: an instruction fetched at edge N shall appear with instr_valid=1 in the cycle after edge N, i.e. one cycle from imem_a to instr.
REQ-023 redirect_valid=1 shall, at the next edge, flush all entries (state EMPTY) and set pc = {redirect_pc[31:2], 2'b00}; the head is not consumed that cycle regardless of instr_ready.
REQ-024 Redirect shall take priority over fetch_en, enq and deq in the same cycle.
REQ-025 Back-to-back redirects: the last one shall win; no instruction from an earlier target shall be enqueued.
REQ-026 fetch_en=0 shall not block deq; the buffer drains normally.
REQ-027 instr_valid = (state != EMPTY); instr/instr_pc shall be registered buffer contents with no combinational path from imem_rd.
REQ-028 instr_valid shall not depend combinationally on instr_ready.
REQ-029 With instr_ready held 1 and fetch_en held 1, throughput shall be one instruction per cycle.

Reset
REQ-030 Reset assertion shall immediately, without a clock edge, set pc=RESET_PC, state=EMPTY, all buffer entries to 0, instr_valid=0, instr=0, instr_pc=0, imem_a=RESET_PC[12:2].
REQ-031 Reset asserted mid-operation shall discard buffered entries and any pending redirect; the first enq after deassertion shall fetch RESET_PC.
REQ-032 No enq or deq shall occur on an edge at which reset is asserted.

Verification
REQ-033 Reset release, fetch_en=1, instr_ready=1, memory word k = 32'h1000_0000+k -> instr_valid rises 1 cycle later; instr/instr_pc sequence (32'h10000000,0), (32'h10000001,4), (32'h10000002,8), one per cycle.
REQ-034 instr_ready=0 for 5 cycles after reset release -> state FULL after 2 fetches, pc holds at 8, imem_a=2; instr_ready=1 -> heads at instr_pc 0, 4, 8 on consecutive cycles.
REQ-035 Running stream, redirect_valid=1 with redirect_pc=32'h0000_0103 while FULL and instr_ready=1 -> next cycle instr_valid=0, pc=32'h100, imem_a=11'h040; following cycle instr_pc=32'h100.
REQ-036 Redirect to 32'hFFFF_FFFC, fetch_en=1, instr_ready=1 -> instr_pc sequence FFFFFFFC, 00000000, 00000004; imem_a 11'h7FF then 11'h000.
REQ-037 Reset asserted asynchronously between edges while state ONE -> instr_valid=0 and imem_a=RESET_PC[12:2] before next edge; after release, first instr_pc=RESET_PC.
REQ-038 fetch_en=0 while FULL, instr_ready=1 -> buffer drains in 2 cycles, instr_valid=0, pc unchanged.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch: 32-bit byte PC indexes a combinational imem; fetched words enter a 2-entry FIFO.
// Latency 1 cycle imem_a->instr; redirect flushes and retargets; a full buffer without deq stalls the PC.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [10:0] imem_a,
  input  logic [31:0] imem_rd,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_ent_instr [DEPTH];
  logic [31:0] r_ent_pc    [DEPTH];

  logic w_deq;
  logic w_enq;
  logic w_unused_redirect_lsb;

  assign imem_a      = r_pc[12:2];
  assign instr_valid = (r_state != EMPTY);
  assign instr       = r_ent_instr[0];
  assign instr_pc    = r_ent_pc[0];

  assign w_deq = instr_valid & instr_ready & ~redirect_valid;
  assign w_enq = fetch_en & ~redirect_valid & ((r_state != FULL) | w_deq);

  assign w_unused_redirect_lsb = ^redirect_pc[1:0];

  // Slot 0 is always the head; vacated slots are zeroed so instr/instr_pc read 0 when empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= EMPTY;
      r_pc           <= RESET_PC;
      r_ent_instr[0] <= '0;
      r_ent_instr[1] <= '0;
      r_ent_pc[0]    <= '0;
      r_ent_pc[1]    <= '0;
    end else if (redirect_valid) begin
      r_state        <= EMPTY;
      r_pc           <= {redirect_pc[31:2], 2'b00};
      r_ent_instr[0] <= '0;
      r_ent_instr[1] <= '0;
      r_ent_pc[0]    <= '0;
      r_ent_pc[1]    <= '0;
    end else begin
      if (w_enq) begin
        r_pc <= r_pc + 32'd4;
      end
      case (r_state)
        EMPTY: begin
          if (w_enq) begin
            r_ent_instr[0] <= imem_rd;
            r_ent_pc[0]    <= r_pc;
            r_state        <= ONE;
          end
        end
        ONE: begin
          if (w_enq && w_deq) begin
            r_ent_instr[0] <= imem_rd;
            r_ent_pc[0]    <= r_pc;
          end else if (w_enq) begin
            r_ent_instr[1] <= imem_rd;
            r_ent_pc[1]    <= r_pc;
            r_state        <= FULL;
          end else if (w_deq) begin
            r_ent_instr[0] <= '0;
            r_ent_pc[0]    <= '0;
            r_state        <= EMPTY;
          end
        end
        FULL: begin
          if (w_deq) begin
            r_ent_instr[0] <= r_ent_instr[1];
            r_ent_pc[0]    <= r_ent_pc[1];
            r_ent_instr[1] <= w_enq ? imem_rd : 32'd0;
            r_ent_pc[1]    <= w_enq ? r_pc : 32'd0;
            r_state        <= w_enq ? FULL : ONE;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic against a queue model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [10:0] imem_a;
  logic [31:0] imem_rd;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  logic [31:0] mem [2048];
  assign imem_rd = mem[imem_a];

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO of fetched {pc, word} pairs plus a byte PC.
  logic [31:0] m_pc;
  logic [31:0] q_pc  [$];
  logic [31:0] q_ins [$];

  fetch_unit #(.RESET_PC(32'h00000000), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_a(imem_a), .imem_rd(imem_rd),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    q_pc.delete();
    q_ins.delete();
    m_pc = 32'h00000000;
  endtask

  task automatic do_reset();
    fetch_en = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    reset = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Applies one cycle of inputs, advances the model, then waits to just after the edge.
  task automatic step(input bit fen, input bit rdy, input bit redir, input logic [31:0] rpc);
    bit deq, enq;
    fetch_en = fen; instr_ready = rdy; redirect_valid = redir; redirect_pc = rpc;
    deq = (q_pc.size() != 0) && rdy && !redir;
    enq = fen && !redir && ((q_pc.size() < 2) || deq);
    if (redir) begin
      q_pc.delete(); q_ins.delete();
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      if (deq) begin
        void'(q_pc.pop_front()); void'(q_ins.pop_front());
      end
      if (enq) begin
        q_pc.push_back(m_pc); q_ins.push_back(mem[m_pc[12:2]]);
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_clear();
    #2;
    checks++;
    if ({instr_valid, instr_pc, instr, imem_a} !== {1'b0, 32'h0, 32'h0, 11'h0}) begin
      errors++;
      $display("FAIL reset_async: got v=%b pc=%h i=%h a=%h required 0/0/0/0", instr_valid, instr_pc, instr, imem_a);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    checks++;
    if ({instr_valid, instr_pc, instr, imem_a} !== {1'b0, 32'h0, 32'h0, 11'h0}) begin
      errors++;
      $display("FAIL reset_held: got v=%b pc=%h i=%h a=%h required 0/0/0/0", instr_valid, instr_pc, instr, imem_a);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc [3];
    do_reset();
    exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8;
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 0, 32'h0);
      checks++;
      if ({instr_valid, instr_pc, instr} !== {1'b1, exp_pc[k], 32'h10000000 + k}) begin
        errors++;
        $display("FAIL stream_%0d: got v=%b pc=%h i=%h required 1/%h/%h", k, instr_valid, instr_pc, instr, exp_pc[k], 32'h10000000 + k);
      end
    end
    checks++;
    if (imem_a !== 11'd3) begin
      errors++;
      $display("FAIL stream_imem_a: got %h required 003", imem_a);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int k = 0; k < 5; k++) step(1, 0, 0, 32'h0);
    checks++;
    if ({instr_valid, instr_pc, imem_a} !== {1'b1, 32'h0, 11'd2}) begin
      errors++;
      $display("FAIL bp_full: got v=%b pc=%h a=%h required 1/00000000/002", instr_valid, instr_pc, imem_a);
    end
    step(1, 1, 0, 32'h0);
    checks++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h4, 32'h10000001}) begin
      errors++;
      $display("FAIL bp_head4: got v=%b pc=%h i=%h required 1/00000004/10000001", instr_valid, instr_pc, instr);
    end
    step(1, 1, 0, 32'h0);
    checks++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h8, 32'h10000002}) begin
      errors++;
      $display("FAIL bp_head8: got v=%b pc=%h i=%h required 1/00000008/10000002", instr_valid, instr_pc, instr);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    step(1, 0, 0, 32'h0);
    step(1, 0, 0, 32'h0);
    step(1, 1, 1, 32'h00000103);
    checks++;
    if ({instr_valid, instr_pc, instr, imem_a} !== {1'b0, 32'h0, 32'h0, 11'h040}) begin
      errors++;
      $display("FAIL redirect_flush: got v=%b pc=%h i=%h a=%h required 0/0/0/040", instr_valid, instr_pc, instr, imem_a);
    end
    step(1, 1, 0, 32'h0);
    checks++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h100, 32'h10000040}) begin
      errors++;
      $display("FAIL redirect_target: got v=%b pc=%h i=%h required 1/00000100/10000040", instr_valid, instr_pc, instr);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    step(1, 1, 1, 32'hFFFFFFFC);
    checks++;
    if ({instr_valid, imem_a} !== {1'b0, 11'h7FF}) begin
      errors++;
      $display("FAIL wrap_redirect: got v=%b a=%h required 0/7ff", instr_valid, imem_a);
    end
    step(1, 1, 0, 32'h0);
    checks++;
    if ({instr_valid, instr_pc, instr, imem_a} !== {1'b1, 32'hFFFFFFFC, 32'h100007FF, 11'h000}) begin
      errors++;
      $display("FAIL wrap_top: got v=%b pc=%h i=%h a=%h required 1/fffffffc/100007ff/000", instr_valid, instr_pc, instr, imem_a);
    end
    step(1, 1, 0, 32'h0);
    checks++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h0, 32'h10000000}) begin
      errors++;
      $display("FAIL wrap_zero: got v=%b pc=%h i=%h required 1/00000000/10000000", instr_valid, instr_pc, instr);
    end
    step(1, 1, 0, 32'h0);
    checks++;
    if ({instr_valid, instr_pc} !== {1'b1, 32'h4}) begin
      errors++;
      $display("FAIL wrap_four: got v=%b pc=%h required 1/00000004", instr_valid, instr_pc);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(1, 1, 0, 32'h0);
    step(1, 1, 1, 32'h00000200);
    step(1, 1, 1, 32'h00000301);
    checks++;
    if ({instr_valid, imem_a} !== {1'b0, 11'h0C0}) begin
      errors++;
      $display("FAIL b2b_redirect: got v=%b a=%h required 0/0c0", instr_valid, imem_a);
    end
    step(1, 1, 0, 32'h0);
    checks++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h300, 32'h100000C0}) begin
      errors++;
      $display("FAIL b2b_first: got v=%b pc=%h i=%h required 1/00000300/100000c0", instr_valid, instr_pc, instr);
    end
    step(1, 1, 0, 32'h0);
    checks++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h304, 32'h100000C1}) begin
      errors++;
      $display("FAIL b2b_second: got v=%b pc=%h i=%h required 1/00000304/100000c1", instr_valid, instr_pc, instr);
    end
  endtask

  task automatic test_drain();
    do_reset();
    step(1, 0, 0, 32'h0);
    step(1, 0, 0, 32'h0);
    step(0, 1, 0, 32'h0);
    checks++;
    if ({instr_valid, instr_pc, instr, imem_a} !== {1'b1, 32'h4, 32'h10000001, 11'd2}) begin
      errors++;
      $display("FAIL drain_one: got v=%b pc=%h i=%h a=%h required 1/4/10000001/002", instr_valid, instr_pc, instr, imem_a);
    end
    step(0, 1, 0, 32'h0);
    checks++;
    if ({instr_valid, instr_pc, instr, imem_a} !== {1'b0, 32'h0, 32'h0, 11'd2}) begin
      errors++;
      $display("FAIL drain_empty: got v=%b pc=%h i=%h a=%h required 0/0/0/002", instr_valid, instr_pc, instr, imem_a);
    end
    step(0, 1, 0, 32'h0);
    checks++;
    if ({instr_valid, imem_a} !== {1'b0, 11'd2}) begin
      errors++;
      $display("FAIL drain_hold: got v=%b a=%h required 0/002", instr_valid, imem_a);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1, 0, 0, 32'h0);
    step(1, 1, 0, 32'h0);
    checks++;
    if ({instr_valid, instr_pc, imem_a} !== {1'b1, 32'h4, 11'd2}) begin
      errors++;
      $display("FAIL areset_pre: got v=%b pc=%h a=%h required 1/00000004/002", instr_valid, instr_pc, imem_a);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h00000500;
    #2 reset = 1'b1;
    model_clear();
    #1;
    checks++;
    if ({instr_valid, instr_pc, instr, imem_a} !== {1'b0, 32'h0, 32'h0, 11'h0}) begin
      errors++;
      $display("FAIL areset_immediate: got v=%b pc=%h i=%h a=%h required 0/0/0/000", instr_valid, instr_pc, instr, imem_a);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({instr_valid, imem_a} !== {1'b0, 11'h0}) begin
      errors++;
      $display("FAIL areset_over_redirect: got v=%b a=%h required 0/000", instr_valid, imem_a);
    end
    redirect_valid = 1'b0;
    reset = 1'b0;
    step(1, 1, 0, 32'h0);
    checks++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h0, 32'h10000000}) begin
      errors++;
      $display("FAIL areset_first: got v=%b pc=%h i=%h required 1/00000000/10000000", instr_valid, instr_pc, instr);
    end
  endtask

  task automatic test_random();
    bit          fen, rdy, redir;
    logic [31:0] rpc;
    logic [31:0] e_pc, e_ins;
    bit          e_v;
    for (int k = 0; k < 2048; k++) mem[k] = $urandom;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        fen   = ($urandom_range(0, 3) != 0);
        rdy   = ($urandom_range(0, 9) < 7);
        redir = ($urandom_range(0, 15) == 0);
        rpc   = $urandom;
        step(fen, rdy, redir, rpc);
      end
      e_v   = (q_pc.size() != 0);
      e_pc  = e_v ? q_pc[0] : 32'h0;
      e_ins = e_v ? q_ins[0] : 32'h0;
      checks++;
      if ({instr_valid, instr_pc, instr, imem_a} !== {e_v, e_pc, e_ins, m_pc[12:2]}) begin
        errors++;
        $display("FAIL random_%0d: got v=%b pc=%h i=%h a=%h required %b/%h/%h/%h",
                 n, instr_valid, instr_pc, instr, imem_a, e_v, e_pc, e_ins, m_pc[12:2]);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2048; k++) mem[k] = 32'h10000000 + k;
    model_clear();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_back_to_back();
    test_drain();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
